ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline, directly downstream of the ALU control decoder. It consumes the ID/EX operands plus the decoder outputs `ALUCtrl`, `Shift`, `JumpReg` and `Jalr`, and computes the ALU or shift result and the link value. It resolves `jr`/`jalr` redirects and branch outcomes for the branch predictor, and holds the EX/MEM pipeline register under stall and flush control.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/alu_core.sv | 34 +++
 rtl/ex_stage.sv | 92 +++++++++
 tb/tb_ex_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU codes, datapath width default and EX/MEM control bundle
package mips_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NE  = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;
  localparam logic [3:0] ALU_SRL = 4'b1100;
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } exmem_ctrl_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU/shifter with equality flag for branch resolution
module alu_core
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_ctrl,
  input  logic [4:0]      i_shamt,
  output logic [XLEN-1:0] o_result,
  output logic            o_eq
);
  logic w_lt;
  assign o_eq = i_a == i_b;
  assign w_lt = $signed(i_a) < $signed(i_b);
  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_NOR: o_result = ~(i_a | i_b);
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_NE:  o_result = {{(XLEN-1){1'b0}}, ~o_eq};
      ALU_SLT: o_result = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLL: o_result = i_b << i_shamt;
      ALU_SRL: o_result = i_b >> i_shamt;
      ALU_SRA: o_result = $signed(i_b) >>> i_shamt;
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with jr/jalr redirect, branch resolution and EX/MEM register
module ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      ALUCtrl,
  input  logic            Shift,
  input  logic            JumpReg,
  input  logic            Jalr,
  input  logic            ALUSrc,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [4:0]      shamt,
  input  logic [4:0]      rd_addr,
  input  logic            RegWrite,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemToReg,
  input  logic            is_branch,
  input  logic            pred_taken,
  input  logic            stall,
  input  logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_target,
  output logic            mispredict,
  output logic            ex_mem_valid,
  output logic [XLEN-1:0] ex_mem_result,
  output logic [XLEN-1:0] ex_mem_wdata,
  output logic [4:0]      ex_mem_rd,
  output logic            ex_mem_regwrite,
  output logic            ex_mem_memread,
  output logic            ex_mem_memwrite,
  output logic            ex_mem_memtoreg,
  output logic            bp_upd_valid,
  output logic            bp_upd_taken
);
  logic [XLEN-1:0] w_b, w_alu, w_result;
  logic            w_eq, w_live, w_actual, w_br;
  exmem_ctrl_t     w_ctrl, r_ctrl;
  // shifts always take rt as the shifted operand
  assign w_b = (ALUSrc & ~Shift) ? imm_ext : rt_data;
  alu_core #(.XLEN(XLEN)) u_alu (
    .i_a(rs_data), .i_b(w_b), .i_ctrl(ALUCtrl), .i_shamt(shamt),
    .o_result(w_alu), .o_eq(w_eq)
  );
  assign w_result = Jalr ? pc_plus4 : w_alu;
  assign w_live = in_valid & ~stall & ~flush;
  assign w_actual = (ALUCtrl == ALU_SUB) ? w_eq : (ALUCtrl == ALU_NE) ? ~w_eq : 1'b0;
  assign w_br = w_live & is_branch;
  assign redirect_valid = w_live & JumpReg;
  assign redirect_target = in_valid ? rs_data : '0;
  assign mispredict = w_br & (w_actual != pred_taken);
  // plain jr has no link, so its write-back is suppressed
  assign w_ctrl = {RegWrite & (Jalr | ~JumpReg), MemRead, MemWrite, MemToReg} & {4{in_valid}};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_valid  <= 1'b0;
      ex_mem_result <= '0;
      ex_mem_wdata  <= '0;
      ex_mem_rd     <= '0;
      r_ctrl        <= '0;
      bp_upd_valid  <= 1'b0;
      bp_upd_taken  <= 1'b0;
    end else begin
      bp_upd_valid <= w_br;
      bp_upd_taken <= w_br & w_actual;
      if (flush) begin
        ex_mem_valid  <= 1'b0;
        ex_mem_result <= '0;
        ex_mem_wdata  <= '0;
        ex_mem_rd     <= '0;
        r_ctrl        <= '0;
      end else if (!stall) begin
        ex_mem_valid  <= in_valid;
        ex_mem_result <= w_result;
        ex_mem_wdata  <= rt_data;
        ex_mem_rd     <= rd_addr;
        r_ctrl        <= w_ctrl;
      end
    end
  end
  assign ex_mem_regwrite = r_ctrl.regwrite;
  assign ex_mem_memread  = r_ctrl.memread;
  assign ex_mem_memwrite = r_ctrl.memwrite;
  assign ex_mem_memtoreg = r_ctrl.memtoreg;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vector table plus hand sequences for redirect, branch, stall, flush and reset
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, Shift, JumpReg, Jalr, ALUSrc;
  logic [3:0]  ALUCtrl;
  logic [31:0] rs_data, rt_data, imm_ext, pc_plus4;
  logic [4:0]  shamt, rd_addr;
  logic        RegWrite, MemRead, MemWrite, MemToReg, is_branch, pred_taken, stall, flush;
  logic        redirect_valid, mispredict, ex_mem_valid, bp_upd_valid, bp_upd_taken;
  logic [31:0] redirect_target, ex_mem_result, ex_mem_wdata;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ALUCtrl(ALUCtrl), .Shift(Shift),
    .JumpReg(JumpReg), .Jalr(Jalr), .ALUSrc(ALUSrc), .rs_data(rs_data), .rt_data(rt_data),
    .imm_ext(imm_ext), .pc_plus4(pc_plus4), .shamt(shamt), .rd_addr(rd_addr),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .is_branch(is_branch), .pred_taken(pred_taken), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .mispredict(mispredict),
    .ex_mem_valid(ex_mem_valid), .ex_mem_result(ex_mem_result), .ex_mem_wdata(ex_mem_wdata),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
    .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_memtoreg(ex_mem_memtoreg),
    .bp_upd_valid(bp_upd_valid), .bp_upd_taken(bp_upd_taken)
  );
  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic        shift;
    logic        alusrc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [3:0]  ctl;
    logic [31:0] exp;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle();
    in_valid = 0; ALUCtrl = 0; Shift = 0; JumpReg = 0; Jalr = 0; ALUSrc = 0;
    rs_data = 0; rt_data = 0; imm_ext = 0; pc_plus4 = 0; shamt = 0; rd_addr = 0;
    RegWrite = 0; MemRead = 0; MemWrite = 0; MemToReg = 0; is_branch = 0; pred_taken = 0;
    stall = 0; flush = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] regs_or();
    return ex_mem_result | ex_mem_wdata | {27'd0, ex_mem_rd} |
      {25'd0, ex_mem_valid, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite,
       ex_mem_memtoreg, bp_upd_valid, bp_upd_taken};
  endfunction
  task automatic load_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    idle();
    in_valid = 1; ALUCtrl = c; rs_data = a; rt_data = b; rd_addr = 5'd9; RegWrite = 1;
  endtask
  logic [31:0] held;
  initial begin
    idle();
    rst = 1;
    v.push_back('{"add_wrap", 4'b0010, 0, 1, 32'h7FFFFFFF, 32'h12345678, 32'h1, 5'd0, 4'b1000, 32'h80000000});
    v.push_back('{"sub_wrap", 4'b0110, 0, 0, 32'h0, 32'h1, 32'h0, 5'd0, 4'b1000, 32'hFFFFFFFF});
    v.push_back('{"and", 4'b0000, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd0, 4'b1000, 32'hF000F000});
    v.push_back('{"or_imm", 4'b0001, 0, 1, 32'h0F0F0000, 32'h0, 32'h000000F0, 5'd0, 4'b1000, 32'h0F0F00F0});
    v.push_back('{"nor", 4'b1000, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 4'b1000, 32'hFFFFFFFF});
    v.push_back('{"xor", 4'b1001, 0, 0, 32'hAAAA5555, 32'hFFFF0000, 32'h0, 5'd0, 4'b1000, 32'h55555555});
    v.push_back('{"ne", 4'b0011, 0, 0, 32'h3, 32'h4, 32'h0, 5'd0, 4'b1000, 32'h1});
    v.push_back('{"slt_neg", 4'b0111, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd0, 4'b1000, 32'h1});
    v.push_back('{"slt_pos", 4'b0111, 0, 0, 32'h1, 32'hFFFFFFFF, 32'h0, 5'd0, 4'b1000, 32'h0});
    v.push_back('{"sra", 4'b1011, 1, 0, 32'h5, 32'hF0000000, 32'h0, 5'd4, 4'b1000, 32'hFF000000});
    v.push_back('{"srl", 4'b1100, 1, 0, 32'h5, 32'hF0000000, 32'h0, 5'd4, 4'b1000, 32'h0F000000});
    v.push_back('{"sll", 4'b1010, 1, 1, 32'h0, 32'h1, 32'hFFFF, 5'd31, 4'b1000, 32'h80000000});
    v.push_back('{"illegal", 4'b1111, 0, 0, 32'h5, 32'h6, 32'h0, 5'd0, 4'b1000, 32'h0});
    v.push_back('{"store", 4'b0010, 0, 1, 32'h1000, 32'hCAFEF00D, 32'h10, 5'd0, 4'b0010, 32'h1010});
    v.push_back('{"load", 4'b0010, 0, 1, 32'h2000, 32'h0, 32'hFFFFFFFC, 5'd0, 4'b1101, 32'h1FFC});
    #12;
    chk("reset_regs", regs_or(), 32'h0);
    rst = 0;
    foreach (v[i]) begin
      @(negedge clk);
      idle();
      in_valid = 1; ALUCtrl = v[i].ctrl; Shift = v[i].shift; ALUSrc = v[i].alusrc;
      rs_data = v[i].rs; rt_data = v[i].rt; imm_ext = v[i].imm; shamt = v[i].sh;
      rd_addr = 5'(i + 1);
      {RegWrite, MemRead, MemWrite, MemToReg} = v[i].ctl;
      tick();
      chk({v[i].name, "_result"}, ex_mem_result, v[i].exp);
      chk({v[i].name, "_wdata"}, ex_mem_wdata, v[i].rt);
      chk({v[i].name, "_rd"}, {27'd0, ex_mem_rd}, 32'(i + 1));
      chk({v[i].name, "_ctl"}, {27'd0, ex_mem_valid, ex_mem_regwrite, ex_mem_memread,
          ex_mem_memwrite, ex_mem_memtoreg}, {27'd1, v[i].ctl});
    end
    // jalr: redirect now, link value next cycle
    @(negedge clk);
    idle();
    in_valid = 1; JumpReg = 1; Jalr = 1; RegWrite = 1; rd_addr = 5'd31;
    rs_data = 32'h00400100; pc_plus4 = 32'h00400020; ALUCtrl = 4'b0010;
    #1;
    chk("jalr_redirect", {31'd0, redirect_valid}, 32'd1);
    chk("jalr_target", redirect_target, 32'h00400100);
    tick();
    chk("jalr_link", ex_mem_result, 32'h00400020);
    chk("jalr_regwrite", {31'd0, ex_mem_regwrite}, 32'd1);
    @(negedge clk);
    Jalr = 0;
    #1;
    chk("jr_redirect", {31'd0, redirect_valid}, 32'd1);
    tick();
    chk("jr_regwrite", {31'd0, ex_mem_regwrite}, 32'd0);
    chk("jr_valid", {31'd0, ex_mem_valid}, 32'd1);
    // invalid slot: combinational outputs zero and controls load as 0
    @(negedge clk);
    in_valid = 0; JumpReg = 1; is_branch = 1; pred_taken = 1; MemWrite = 1;
    #1;
    chk("inv_comb", {30'd0, redirect_valid, mispredict}, 32'd0);
    chk("inv_target", redirect_target, 32'd0);
    tick();
    chk("inv_regs", {27'd0, ex_mem_valid, ex_mem_regwrite, ex_mem_memread,
        ex_mem_memwrite, ex_mem_memtoreg}, 32'd0);
    chk("inv_bp", {31'd0, bp_upd_valid}, 32'd0);
    // bne not taken, predicted taken
    @(negedge clk);
    idle();
    in_valid = 1; ALUCtrl = 4'b0011; is_branch = 1; rs_data = 5; rt_data = 5; pred_taken = 1;
    #1;
    chk("bne_mispredict", {31'd0, mispredict}, 32'd1);
    tick();
    chk("bne_bp", {30'd0, bp_upd_valid, bp_upd_taken}, 32'b10);
    // beq taken, predicted taken
    @(negedge clk);
    ALUCtrl = 4'b0110;
    #1;
    chk("beq_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    chk("beq_bp", {30'd0, bp_upd_valid, bp_upd_taken}, 32'b11);
    @(negedge clk);
    is_branch = 0;
    tick();
    chk("bp_one_shot", {31'd0, bp_upd_valid}, 32'd0);
    // stall for 3 cycles with a pending jr
    load_alu(4'b0010, 32'h100, 32'h23);
    tick();
    held = ex_mem_result;
    chk("pre_stall", held, 32'h123);
    @(negedge clk);
    idle();
    in_valid = 1; JumpReg = 1; rs_data = 32'hDEAD0000; rt_data = 32'h1; ALUCtrl = 4'b0010;
    is_branch = 1; stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_redirect", {30'd0, redirect_valid, mispredict}, 32'd0);
      tick();
      chk("stall_hold", ex_mem_result, held);
      chk("stall_bp", {31'd0, bp_upd_valid}, 32'd0);
      @(negedge clk);
    end
    stall = 0;
    #1;
    chk("unstall_redirect", {31'd0, redirect_valid}, 32'd1);
    tick();
    chk("unstall_load", ex_mem_result, 32'hDEAD0001);
    // flush wins over stall
    load_alu(4'b0001, 32'hF0, 32'h0F);
    MemToReg = 1;
    tick();
    chk("pre_flush", ex_mem_result, 32'hFF);
    @(negedge clk);
    stall = 1; flush = 1; JumpReg = 1;
    #1;
    chk("flush_redirect", {31'd0, redirect_valid}, 32'd0);
    tick();
    chk("flush_regs", regs_or(), 32'd0);
    // async reset mid-cycle
    load_alu(4'b0010, 32'h10, 32'h20);
    ALUCtrl = 4'b0110; is_branch = 1; MemRead = 1;
    tick();
    chk("pre_rst_bp", {31'd0, bp_upd_valid}, 32'd1);
    @(negedge clk);
    stall = 1;
    #1;
    rst = 1;
    #1;
    chk("async_rst", regs_or(), 32'd0);
    #1;
    rst = 0;
    @(negedge clk);
    stall = 0; is_branch = 0; ALUCtrl = 4'b0010;
    tick();
    chk("post_rst_load", ex_mem_result, 32'h30);
    chk("post_rst_valid", {29'd0, ex_mem_valid, ex_mem_regwrite, ex_mem_memread}, 32'b111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
